ase_txn_tracker: RTL and testbench

Parametrised, multi-channel transaction tracker for the ASE simulation fabric, sitting passively beside the CCI-P request/response path. It records every outstanding request by (channel, tag) and retires it beat-by-beat as responses return. It flags duplicate tags, orphan responses and (optionally) timed-out requests as registered error pulses, with first-error capture. It extends single-stream checking to NUM_CH channels, multi-beat requests and bounded storage.

---
 rtl/ase_txn_tracker.sv | 145 ++++++++++++++
 tb/tb_ase_txn_tracker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ase_txn_tracker.sv
// ase_txn_tracker: per-(channel,tag) outstanding-request tracker with dup/orphan/timeout error capture.
// Optional timeout logic is compiled in with `define ASE_TRACKER_TIMEOUT_EN.
module ase_txn_tracker #(
    parameter int NUM_CH = 2,
    parameter int TAG_WIDTH = 8,
    parameter int LEN_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int D = NUM_CH * (2 ** TAG_WIDTH),
    localparam int OW = $clog2(D + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [CHW-1:0]       req_ch,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 rsp_valid,
    input  logic [CHW-1:0]       rsp_ch,
    input  logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [OW-1:0]        outstanding,
    output logic                 idle,
    output logic                 err_dup,
    output logic                 err_orphan,
    output logic                 err_timeout,
    output logic                 err_sticky,
    output logic [1:0]           err_code,
    output logic [CHW-1:0]       err_ch,
    output logic [TAG_WIDTH-1:0] err_tag
);
    localparam int IW = CHW + TAG_WIDTH;
    localparam logic [CHW:0] NCH = (CHW + 1)'(NUM_CH);

    logic [D-1:0]         valid;
    logic [LEN_WIDTH-1:0] rem [D];
    logic [IW-1:0]        ri, qi, ti;
    logic                 rsp_in, rsp_live, rsp_free, rsp_orph;
    logic                 req_in, req_orph, dup, alloc, orph, to_fire;
    logic [OW-1:0]        nxt;

    // A response is judged against pre-cycle state; the request sees the post-response state.
    always_comb begin
        ri = {rsp_ch, rsp_tag};
        qi = {req_ch, req_tag};
        rsp_in = rsp_valid && ({1'b0, rsp_ch} < NCH);
        rsp_live = rsp_in && valid[ri];
        rsp_free = rsp_live && (rem[ri] == '0);
        rsp_orph = rsp_valid && !rsp_live;
        req_in = req_valid && ({1'b0, req_ch} < NCH);
        req_orph = req_valid && !req_in;
        dup = req_in && valid[qi] && !(rsp_free && ri == qi);
        alloc = req_in && !dup;
        orph = rsp_orph || req_orph;
        nxt = outstanding + OW'(alloc) - OW'(rsp_free) - OW'(to_fire);
    end

`ifdef ASE_TRACKER_TIMEOUT_EN
    localparam int P = TIMEOUT_CYCLES / 4;
    localparam int PW = $clog2(P);

    logic [PW-1:0] pre;
    logic [1:0]    age [D];
    logic [D-1:0]  expd;
    logic          wrap, found;

    assign wrap = pre == PW'(P - 1);

    // Lowest index wins; an entry touched this cycle is not reported since the touch cancels it.
    always_comb begin
        found = 1'b0;
        ti = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (expd[i]) begin
                found = 1'b1;
                ti = IW'(i);
            end
        end
        to_fire = found && !(rsp_live && ri == ti) && !(req_in && qi == ti);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            expd <= '0;
            for (int i = 0; i < D; i++) age[i] <= 2'd0;
        end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            for (int i = 0; i < D; i++) begin
                if (wrap && valid[i]) begin
                    age[i] <= (age[i] == 2'd3) ? 2'd3 : age[i] + 2'd1;
                    if (age[i] == 2'd3) expd[i] <= 1'b1;
                end
            end
            if (rsp_live) begin
                age[ri] <= 2'd0;
                expd[ri] <= 1'b0;
            end
            if (req_in) begin
                age[qi] <= 2'd0;
                expd[qi] <= 1'b0;
            end
            if (to_fire) expd[ti] <= 1'b0;
        end
    end
`else
    assign to_fire = 1'b0;
    assign ti = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            outstanding <= '0;
            idle <= 1'b1;
            err_dup <= 1'b0;
            err_orphan <= 1'b0;
            err_timeout <= 1'b0;
            err_sticky <= 1'b0;
            err_code <= 2'd0;
            err_ch <= '0;
            err_tag <= '0;
        end else begin
            if (rsp_live) begin
                if (rsp_free) valid[ri] <= 1'b0;
                else rem[ri] <= rem[ri] - 1'b1;
            end
            if (req_in) begin
                valid[qi] <= 1'b1;
                rem[qi] <= req_len;
            end
            if (to_fire) valid[ti] <= 1'b0;
            outstanding <= nxt;
            idle <= nxt == '0;
            err_dup <= dup;
            err_orphan <= orph;
            err_timeout <= to_fire;
            if (!err_sticky && (dup || orph || to_fire)) begin
                err_sticky <= 1'b1;
                err_code <= dup ? 2'd1 : orph ? 2'd2 : 2'd3;
                err_ch <= dup ? req_ch : rsp_orph ? rsp_ch : orph ? req_ch : ti[IW-1:TAG_WIDTH];
                err_tag <= dup ? req_tag : rsp_orph ? rsp_tag : orph ? req_tag : ti[TAG_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_ase_txn_tracker.sv
// tb_ase_txn_tracker: table-driven directed checks plus hand sequences for sticky, reset and timeout cases.
module tb_ase_txn_tracker;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, rsp_valid;
    logic [0:0] req_ch, rsp_ch;
    logic [7:0] req_tag, rsp_tag;
    logic [1:0] req_len;
    logic [9:0] outstanding;
    logic       idle, err_dup, err_orphan, err_timeout, err_sticky;
    logic [1:0] err_code;
    logic [0:0] err_ch;
    logic [7:0] err_tag;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ase_txn_tracker #(.NUM_CH(2), .TAG_WIDTH(8), .LEN_WIDTH(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ch(req_ch), .req_tag(req_tag), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_tag(rsp_tag),
        .outstanding(outstanding), .idle(idle),
        .err_dup(err_dup), .err_orphan(err_orphan), .err_timeout(err_timeout),
        .err_sticky(err_sticky), .err_code(err_code), .err_ch(err_ch), .err_tag(err_tag)
    );

    typedef struct {
        logic       qv;
        logic [0:0] qc;
        logic [7:0] qt;
        logic [1:0] ql;
        logic       sv;
        logic [0:0] sc;
        logic [7:0] st;
        logic [9:0] eo;
        logic       ei;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic qv, input logic [0:0] qc, input logic [7:0] qt, input logic [1:0] ql,
                        input logic sv, input logic [0:0] sc, input logic [7:0] st);
        req_valid = qv; req_ch = qc; req_tag = qt; req_len = ql;
        rsp_valid = sv; rsp_ch = sc; rsp_tag = st;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int  cyc;
    logic seen;

    initial begin
        req_valid = 0; req_ch = 0; req_tag = 0; req_len = 0;
        rsp_valid = 0; rsp_ch = 0; rsp_tag = 0;
        vecs[0]  = '{1, 0, 8'h10, 3, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 8'h00, 0, 1, 0, 8'h10, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 0, 8'h10, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 8'h00, 0, 1, 0, 8'h10, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 0, 8'h10, 0, 1, 0, 0};
        vecs[5]  = '{1, 1, 8'h05, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[7]  = '{1, 1, 8'h05, 0, 0, 0, 8'h00, 1, 0, 1, 0};
        vecs[8]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 8'h01, 0, 0, 0, 8'h00, 2, 0, 0, 0};
        vecs[10] = '{1, 0, 8'h01, 1, 1, 0, 8'h01, 2, 0, 0, 0};
        vecs[11] = '{0, 0, 8'h00, 0, 1, 0, 8'h01, 2, 0, 0, 0};
        vecs[12] = '{1, 0, 8'h01, 0, 1, 0, 8'h01, 2, 0, 0, 0};
        vecs[13] = '{0, 0, 8'h00, 0, 1, 0, 8'h22, 2, 0, 0, 1};
        vecs[14] = '{0, 0, 8'h00, 0, 1, 1, 8'h05, 1, 0, 0, 0};
        vecs[15] = '{0, 0, 8'h00, 0, 1, 0, 8'h01, 0, 1, 0, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_code", 32'(err_code), 0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].qv, vecs[i].qc, vecs[i].qt, vecs[i].ql, vecs[i].sv, vecs[i].sc, vecs[i].st);
            chk($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].eo));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].ei));
            chk($sformatf("v%0d_dup", i), 32'(err_dup), 32'(vecs[i].ed));
            chk($sformatf("v%0d_orphan", i), 32'(err_orphan), 32'(vecs[i].er));
            chk($sformatf("v%0d_timeout", i), 32'(err_timeout), 0);
        end
        chk("tbl_sticky", 32'(err_sticky), 1);
        chk("tbl_code", 32'(err_code), 1);
        chk("tbl_ch", 32'(err_ch), 1);
        chk("tbl_tag", 32'(err_tag), 32'h05);

        // orphan first, then a dup must not disturb the capture
        do_reset();
        step(0, 0, 8'h00, 0, 1, 0, 8'h22);
        chk("orph_pulse", 32'(err_orphan), 1);
        chk("orph_code", 32'(err_code), 2);
        chk("orph_ch", 32'(err_ch), 0);
        chk("orph_tag", 32'(err_tag), 32'h22);
        step(0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("orph_pulse_end", 32'(err_orphan), 0);
        chk("orph_sticky", 32'(err_sticky), 1);
        step(1, 1, 8'h05, 0, 0, 0, 8'h00);
        step(0, 0, 8'h00, 0, 0, 0, 8'h00);
        step(1, 1, 8'h05, 2, 0, 0, 8'h00);
        chk("dup2_pulse", 32'(err_dup), 1);
        chk("dup2_outstanding", 32'(outstanding), 1);
        chk("dup2_code_kept", 32'(err_code), 2);
        chk("dup2_tag_kept", 32'(err_tag), 32'h22);

        // reset with five live entries
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1'(i % 2), 8'(8'h40 + i), 1, 0, 0, 8'h00);
        chk("five_live", 32'(outstanding), 5);
        rst = 1'b1;
        req_valid = 1'b1; req_ch = 0; req_tag = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        chk("mid_rst_outstanding", 32'(outstanding), 0);
        chk("mid_rst_idle", 32'(idle), 1);
        chk("mid_rst_sticky", 32'(err_sticky), 0);
        chk("mid_rst_code", 32'(err_code), 0);
        chk("mid_rst_dup", 32'(err_dup), 0);
        step(0, 0, 8'h00, 0, 1, 0, 8'h40);
        chk("post_rst_orphan", 32'(err_orphan), 1);
        chk("post_rst_code", 32'(err_code), 2);
        chk("post_rst_tag", 32'(err_tag), 32'h40);

        do_reset();
        step(1, 0, 8'h03, 0, 0, 0, 8'h00);
        step(1, 0, 8'h07, 0, 0, 0, 8'h00);
        cyc = 2;
`ifdef ASE_TRACKER_TIMEOUT_EN
        while (!err_timeout && cyc < 30) begin
            step(0, 0, 8'h00, 0, 0, 0, 8'h00);
            cyc++;
        end
        chk("to_first_seen", 32'(err_timeout), 1);
        chk("to_first_bound", 32'(cyc - 1 <= 16), 1);
        chk("to_code", 32'(err_code), 3);
        chk("to_tag", 32'(err_tag), 32'h03);
        chk("to_mid_outstanding", 32'(outstanding), 1);
        step(0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("to_second_pulse", 32'(err_timeout), 1);
        chk("to_outstanding", 32'(outstanding), 0);
        chk("to_idle", 32'(idle), 1);
        chk("to_tag_kept", 32'(err_tag), 32'h03);
        step(0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("to_pulse_end", 32'(err_timeout), 0);
`else
        seen = 1'b0;
        while (cyc < 40) begin
            step(0, 0, 8'h00, 0, 0, 0, 8'h00);
            seen = seen | err_timeout;
            cyc++;
        end
        chk("nto_no_pulse", 32'(seen), 0);
        chk("nto_outstanding", 32'(outstanding), 2);
        chk("nto_code", 32'(err_code), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
